// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester/transmitter bundle for uart_tx_arbiter.
//   req/req_data : per-requester byte pending and its data (byte i on [8i+7:8i])
//   ack/err      : one-clk completion / timeout pulses, one bit per requester
//   gnt          : one-hot owner while a transfer is in progress
//   busy         : arbiter not idle
//   tx_newd/tx_data/tx_done : connection to the shared uart_tx
// master = arbiter side, slave = requesters + transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   err;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              tx_newd;
  logic [7:0]        tx_data;
  logic              tx_done;

  modport master (
    input  req, req_data, tx_done,
    output ack, err, gnt, busy, tx_newd, tx_data
  );

  modport slave (
    output req, req_data, tx_done,
    input  ack, err, gnt, busy, tx_newd, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NREQ requesters.
// Holds tx_newd for HOLD_CYCLES clks so the slow baud domain sees it, then
// waits for a fresh rising edge of tx_done (ack) or TIMEOUT clks (err).
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset (does not touch the transmitter)
//   bus - uart_tx_arbiter_if.master: req/req_data in, ack/err/gnt/busy out,
//         tx_newd/tx_data out to uart_tx, tx_done in from uart_tx
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 128,
  parameter int TIMEOUT     = 4096
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int unsigned NR = NREQ;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [NREQ-1:0] ack_q, ack_n;
  logic [NREQ-1:0] err_q, err_n;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic            newd_q, newd_n;
  logic [7:0]      data_q, data_n;

  logic            done_s1, done_s2, done_d;
  logic            done_rise;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // tx_done comes from the baud domain; only a rising edge seen after the
  // synchronizer counts, so a level left high by the previous byte is ignored.
  // Deliberately not reset so reset cannot fabricate an edge.
  always_ff @(posedge clk) begin
    done_s1 <= bus.tx_done;
    done_s2 <= done_s1;
    done_d  <= done_s2;
  end

  assign done_rise = done_s2 & ~done_d;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = IW'((32'(ptr) + k) % NR);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx;
    cnt_n   = cnt;
    ack_n   = '0;
    err_n   = '0;
    gnt_n   = gnt_q;
    newd_n  = newd_q;
    data_n  = data_q;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = ISSUE;
          idx_n   = pick;
          gnt_n   = onehot(pick);
          newd_n  = 1'b1;
          data_n  = bus.req_data[{pick, 3'b000} +: 8];
          cnt_n   = '0;
        end
      end
      ISSUE: begin
        if (cnt == HOLD_LAST) begin
          newd_n  = 1'b0;
          cnt_n   = '0;
          state_n = WAIT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT: begin
        // done is checked first so it wins a tie with the timeout
        if (done_rise) begin
          ack_n   = onehot(idx);
          gnt_n   = '0;
          ptr_n   = idx;
          state_n = IDLE;
        end else if (cnt == WAIT_LAST) begin
          err_n   = onehot(idx);
          gnt_n   = '0;
          ptr_n   = idx;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= IW'(NREQ - 1);
      idx    <= '0;
      cnt    <= '0;
      ack_q  <= '0;
      err_q  <= '0;
      gnt_q  <= '0;
      newd_q <= 1'b0;
      data_q <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      ack_q  <= ack_n;
      err_q  <= err_n;
      gnt_q  <= gnt_n;
      newd_q <= newd_n;
      data_q <= data_n;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state != IDLE);
  assign bus.tx_newd = newd_q;
  assign bus.tx_data = data_q;

endmodule
